// File: rtl/basic_rw_gen.sv
// basic_rw_gen: multi-channel ramp generator (IDLE/RAMP/HOLD/DONE) with per-channel array sums; BASIC_RW_GEN_DONE_X_EN drives a to X in DONE
module basic_rw_gen #(
  parameter int NCH = 2,
  parameter int AW = 4,
  parameter int DW = 11,
  parameter int ND = 4,
  parameter int RAMP_LEN = 10,
  parameter int HOLD_LEN = 10,
  localparam int SW = DW + $clog2(ND)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [AW-1:0] step [NCH],
  input  logic [DW-1:0] b [NCH][ND],
  output logic [AW-1:0] a [NCH],
  output logic [SW-1:0] sum [NCH],
  output logic [1:0]    phase,
  output logic          done
);
  localparam int CMAX = RAMP_LEN > HOLD_LEN ? RAMP_LEN : HOLD_LEN;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] a_nxt [NCH];
  logic [SW-1:0] sum_nxt [NCH];
  assign phase = state;
  assign done = state == DONE;
  // next state, counter and ramp values; clr wins over en, en=0 freezes everything
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    a_nxt = a;
    if (clr) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
      a_nxt = '{default: '0};
    end else if (en) begin
      case (state)
        IDLE: begin
          state_nxt = RAMP;
          cnt_nxt = '0;
        end
        RAMP: begin
          for (int k = 0; k < NCH; k++) a_nxt[k] = a[k] + step[k];
          state_nxt = cnt == CW'(RAMP_LEN - 1) ? HOLD : RAMP;
          cnt_nxt = cnt == CW'(RAMP_LEN - 1) ? '0 : cnt + 1'b1;
        end
        HOLD: begin
          state_nxt = cnt == CW'(HOLD_LEN - 1) ? DONE : HOLD;
          cnt_nxt = cnt == CW'(HOLD_LEN - 1) ? '0 : cnt + 1'b1;
`ifdef BASIC_RW_GEN_DONE_X_EN
          if (cnt == CW'(HOLD_LEN - 1)) a_nxt = '{default: 'x};
`else
`endif
        end
        DONE: state_nxt = DONE;
      endcase
    end
  end
  // zero-extended per-channel sum of the input array
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sum_nxt[k] = '0;
      for (int j = 0; j < ND; j++) sum_nxt[k] = sum_nxt[k] + SW'(b[k][j]);
    end
  end
  // state, counter and ramp registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      a <= '{default: '0};
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      a <= a_nxt;
    end
  end
  // sums register every cycle regardless of FSM, en and clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum <= '{default: '0};
    else sum <= sum_nxt;
  end
endmodule
